// File: rtl/qbert_only_timer_sched_pkg.sv
// Shared definitions for the interval-timer scheduler: timer register map,
// control-word bit positions and the sequencer state encoding.
package qbert_only_timer_sched_pkg;

    localparam int IDX_W = 3;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam logic [15:0] CTRL_BASE = 16'((1 << CTL_ITO) | (1 << CTL_START));
    localparam logic [15:0] STOP_WORD = 16'(1 << CTL_STOP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STOP,
        S_PL,
        S_PH,
        S_CTRL,
        S_ACK,
        S_CLR
    } state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/qbert_only_rr_arbiter.sv
// Round-robin requester selection: search begins one past the previous winner.
module qbert_only_rr_arbiter
    import qbert_only_timer_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic             valid
);

    int  idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/qbert_only_timer_scheduler.sv
// Shares one interval timer among NREQ requesters by sequencing its register writes.
// Build option: TIMER_SCHED_STOP_FIRST_EN prepends an explicit STOP write to each programming sequence.
module qbert_only_timer_scheduler
    import qbert_only_timer_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_period,
    input  logic [NREQ-1:0]      req_cont,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      evt,
    output logic                 busy,
    output logic [2:0]           tmr_address,
    output logic                 tmr_chipselect,
    output logic                 tmr_write_n,
    output logic [15:0]          tmr_writedata,
    input  logic                 tmr_irq
);

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

`ifdef TIMER_SCHED_STOP_FIRST_EN
    localparam state_t FIRST_WRITE = S_STOP;
`else
    localparam state_t FIRST_WRITE = S_PL;
`endif

    state_t           state, next_state;
    logic [NREQ-1:0]  grant;
    logic             arb_valid;
    logic             grant_en;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] owner;
    logic             owner_valid;
    logic             owner_cont;
    logic [31:0]      period_q;
    logic             cont_q;

    qbert_only_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .valid      (arb_valid)
    );

    assign grant_idx = onehot_to_idx(8'(grant));
    // A pending timeout is always serviced before a new grant is considered.
    assign grant_en  = (state == S_IDLE) && !tmr_irq && arb_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant  <= IDX_W'(NREQ-1);
            win_idx     <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            owner_cont  <= 1'b0;
            evt         <= '0;
        end else begin
            evt <= '0;
            if (grant_en) begin
                last_grant <= grant_idx;
                win_idx    <= grant_idx;
            end
            if (state == S_ACK) begin
                owner       <= win_idx;
                owner_valid <= 1'b1;
                owner_cont  <= cont_q;
            end
            // A stray interrupt with no owner is cleared without any event.
            if (state == S_CLR && owner_valid) begin
                evt <= ONE << owner;
                if (!owner_cont) owner_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_en) begin
            period_q <= req_period[int'(grant_idx)*32 +: 32];
            cont_q   <= req_cont[grant_idx];
        end
    end

    always_comb begin
        next_state     = state;
        busy           = (state != S_IDLE);
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = '0;
        tmr_writedata  = '0;
        ack            = '0;
        case (state)
            S_IDLE: begin
                if (tmr_irq)        next_state = S_CLR;
                else if (arb_valid) next_state = FIRST_WRITE;
            end
            S_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_CONTROL;
                tmr_writedata  = STOP_WORD;
                next_state     = S_PL;
            end
            S_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_PERIODL;
                tmr_writedata  = period_q[15:0];
                next_state     = S_PH;
            end
            S_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_PERIODH;
                tmr_writedata  = period_q[31:16];
                next_state     = S_CTRL;
            end
            S_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_CONTROL;
                tmr_writedata  = CTRL_BASE | (16'(cont_q) << CTL_CONT);
                next_state     = S_ACK;
            end
            S_ACK: begin
                ack        = ONE << win_idx;
                next_state = S_IDLE;
            end
            S_CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_STATUS;
                tmr_writedata  = 16'h0000;
                next_state     = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule
